// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: 16-bit A-B computed one 4-bit slice per clock with optional signed saturation
module nibble_serial_subtractor #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_diff,
  output logic        out_borrow,
  output logic        out_ovf,
  output logic        out_lt,
  output logic        out_eq
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state, state_n;
  logic [15:0] a_q, nb_q;
  logic [11:0] res_q;
  logic        carry_q;
  logic [1:0]  cnt;
  logic [3:0]  a_sl, b_sl, sum;
  logic        c_out;
  logic [15:0] raw;
  logic        ovf;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign a_sl = a_q[{cnt, 2'b00} +: 4];
  assign b_sl = nb_q[{cnt, 2'b00} +: 4];
  assign {c_out, sum} = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0, carry_q};
  // lower slices shift in from the top, so after three slices res_q holds bits [11:0]
  assign raw = {sum, res_q};
  assign ovf = (a_q[15] == nb_q[15]) & (raw[15] != a_q[15]);
  always_comb begin
    state_n = state == IDLE ? (in_valid ? BUSY : IDLE)
            : state == BUSY ? (cnt == 2'd3 ? DONE : BUSY)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      nb_q       <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
      out_ovf    <= 1'b0;
      out_lt     <= 1'b0;
      out_eq     <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= in_a;
      nb_q    <= ~in_b;
      carry_q <= 1'b1;
      cnt     <= '0;
    end else if (state == BUSY) begin
      res_q   <= {sum, res_q[11:4]};
      carry_q <= c_out;
      cnt     <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        out_diff   <= (SATURATE && ovf) ? (a_q[15] ? 16'h8000 : 16'h7FFF) : raw;
        out_borrow <= ~c_out;
        out_ovf    <= ovf;
        out_lt     <= raw[15] ^ ovf;
        out_eq     <= raw == 16'h0000;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: saturating and wrapping instances driven in lockstep against an arithmetic model
module tb_nibble_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic        rdy_s, rdy_w, vld_s, vld_w;
  logic [15:0] d_s, d_w;
  logic        bo_s, bo_w, ov_s, ov_w, lt_s, lt_w, eq_s, eq_w;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_a(in_a), .in_b(in_b),
    .out_valid(vld_s), .out_ready(out_ready), .out_diff(d_s), .out_borrow(bo_s),
    .out_ovf(ov_s), .out_lt(lt_s), .out_eq(eq_s));

  nibble_serial_subtractor #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_a(in_a), .in_b(in_b),
    .out_valid(vld_w), .out_ready(out_ready), .out_diff(d_w), .out_borrow(bo_w),
    .out_ovf(ov_w), .out_lt(lt_w), .out_eq(eq_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] snap;
    return {d_s, bo_s, ov_s, lt_s, eq_s, d_w[11:0]};
  endfunction

  task automatic check_out(input logic [15:0] a, input logic [15:0] b, input string tag);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int d = sa - sb;
    logic [15:0] raw = a - b;
    logic ov = (d > 32767) || (d < -32768);
    logic [15:0] sat = ov ? (d > 0 ? 16'h7FFF : 16'h8000) : raw;
    chk({tag, " valid"}, {30'b0, vld_s, vld_w}, 32'h3);
    chk({tag, " diff_sat"}, {16'b0, d_s}, {16'b0, sat});
    chk({tag, " diff_wrap"}, {16'b0, d_w}, {16'b0, raw});
    chk({tag, " borrow"}, {30'b0, bo_s, bo_w}, {30'b0, {2{a < b}}});
    chk({tag, " ovf"}, {30'b0, ov_s, ov_w}, {30'b0, {2{ov}}});
    chk({tag, " lt"}, {30'b0, lt_s, lt_w}, {30'b0, {2{sa < sb}}});
    chk({tag, " eq"}, {30'b0, eq_s, eq_w}, {30'b0, {2{a == b}}});
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input string tag);
    int n = 0;
    while (!(rdy_s && rdy_w) && n < 20) begin
      step;
      n++;
    end
    chk({tag, " ready"}, {31'b0, rdy_s & rdy_w}, 32'h1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    chk({tag, " busy_ready"}, {30'b0, rdy_s, rdy_w}, 32'h0);
    chk({tag, " early0"}, {30'b0, vld_s, vld_w}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step;
      chk({tag, " early"}, {30'b0, vld_s, vld_w}, 32'h0);
    end
    step;
    check_out(a, b, tag);
    if (out_ready) begin
      step;
      chk({tag, " release"}, {28'b0, vld_s, vld_w, rdy_s, rdy_w}, 32'h3);
    end
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    step;
    step;
    chk("reset handshake", {28'b0, rdy_s, rdy_w, vld_s, vld_w}, 32'hC);
    chk("reset outputs", snap(), 32'h0);
    chk("reset wrap diff", {16'b0, d_w}, 32'h0);
    rst = 1'b0;

    op(16'h1234, 16'h0034, "basic");
    chk("basic value", {16'b0, d_s}, 32'h1200);
    op(16'h0000, 16'h0001, "neg");
    chk("neg value", {16'b0, d_w}, 32'hFFFF);
    op(16'h5A5A, 16'h5A5A, "equal");
    op(16'h7FFF, 16'hFFFF, "pos_ovf");
    chk("pos_ovf values", {d_s, d_w}, 32'h7FFF_8000);
    op(16'h8000, 16'h0001, "neg_ovf");
    chk("neg_ovf values", {d_s, d_w}, 32'h8000_7FFF);
    op(16'h8000, 16'h8000, "min_eq");
    op(16'h0000, 16'h8000, "zero_minus_min");

    out_ready = 1'b0;
    op(16'h0F00, 16'h00F1, "bp");
    held = snap();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = 16'h1111;
      in_b = 16'h2222;
      step;
      chk("bp stable", snap(), held);
      chk("bp handshake", {28'b0, rdy_s, rdy_w, vld_s, vld_w}, 32'h3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    chk("bp release", {28'b0, rdy_s, rdy_w, vld_s, vld_w}, 32'hC);
    chk("bp kept result", snap(), held);

    in_a = 16'h4444;
    in_b = 16'h1111;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("abort handshake", {28'b0, rdy_s, rdy_w, vld_s, vld_w}, 32'hC);
    chk("abort outputs", snap(), 32'h0);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("abort no valid", {30'b0, vld_s, vld_w}, 32'h0);
    end
    op(16'h0100, 16'h0001, "after_abort");
    chk("after_abort value", {16'b0, d_s}, 32'h00FF);

    rst = 1'b1;
    in_valid = 1'b1;
    step;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_wins ready", {30'b0, rdy_s, rdy_w}, 32'h3);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("rst_wins no valid", {30'b0, vld_s, vld_w}, 32'h0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = (i % 5 == 0) ? 16'h7FFF : 16'($urandom);
      rb = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
      op(ra, rb, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Digit-serial 16-bit two's-complement subtractor computing DIFF = A − B one 4-bit slice per clock, least significant slice first, with the borrow carried between cycles in a register. It is the subtraction counterpart of the team's 16-bit carry-lookahead adder. It serves the autoencoder's error path (target − reconstruction), where area matters more than latency. Operands arrive and results leave through valid/ready handshakes, and signed overflow is optionally saturated.

## Interface
- SATURATE, 1, when 1 signed overflow clamps the result to 0x7FFF or 0x8000; when 0 the wrapped result is returned
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- in_a  in  16  minuend A, two's complement
- in_b  in  16  subtrahend B, two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_diff  out  16  A − B, saturated per SATURATE
- out_borrow  out  1  unsigned borrow (A < B as unsigned)
- out_ovf  out  1  signed overflow occurred (reported even when saturated)
- out_lt  out  1  signed A < B
- out_eq  out  1  A == B

## Operation
- The design uses one clock. Reset is synchronous and active-high.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch in_a and ~in_b, set the carry register to 1, set slice counter cnt=0, then go to BUSY.
  - BUSY: in_ready=0. Each cycle, add slice cnt of A to slice cnt of ~B plus the carry register, using the 4-bit adder slice.
    - Write the 4-bit sum into result bits [4·cnt+3:4·cnt].
    - Update the carry register with the slice carry out.
    - Increment cnt. When cnt==3, go to DONE.
  - DONE: out_valid=1. All outputs are held stable while out_ready=0. When out_ready=1, go to IDLE.
- Flag rules, computed in the cycle the last slice is processed:
  - Let rawdiff be the assembled 16-bit result and c16 the final carry.
  - out_borrow = ~c16.
  - out_ovf = (A[15] ≠ B[15]) & (rawdiff[15] ≠ A[15]).
  - out_lt = rawdiff[15] ^ out_ovf.
  - out_eq = (rawdiff == 0).
- Saturation:
  - SATURATE=1 and ovf: out_diff = A[15] ? 0x8000 : 0x7FFF.
  - Otherwise out_diff = rawdiff.
- in_valid is ignored outside IDLE. Operands presented then are not consumed and must be held by the producer.

## Timing
- Reset values:
  - in_ready=1, out_valid=0.
  - out_diff=0x0000, out_borrow=0, out_ovf=0, out_lt=0, out_eq=0.
  - Internal state IDLE, cnt=0.
- Latency: the acceptance edge (in_valid & in_ready) is edge 0. Slices 0..3 complete on edges 1..4. out_valid and the result outputs are visible after edge 4.
- Throughput: with out_ready held at 1, one operation every 6 cycles.
  - 1 accept cycle.
  - 4 BUSY cycles.
  - 1 DONE/handshake cycle.
  - in_ready returns to 1 on the cycle after the out_valid & out_ready handshake.
- Back-pressure: DONE persists indefinitely while out_ready=0. in_ready stays 0 throughout.
- Reset mid-operation (rst=1 in any state) takes effect at the next edge:
  - State returns to IDLE.
  - The partial result is discarded.
  - All outputs take their reset values.
  - No out_valid is produced for the aborted operation.
- When rst and in_valid are asserted together, rst wins and nothing is accepted.
- The outputs out_diff and the flags change only on the edge entering DONE or on reset. They never change while out_valid=1.

## Test plan
- Basic: A=0x1234, B=0x0034 → out_diff=0x1200, borrow=0, ovf=0, lt=0, eq=0. out_valid rises exactly 4 edges after acceptance.
- Borrow/negative: A=0x0000, B=0x0001 → out_diff=0xFFFF, borrow=1, ovf=0, lt=1. Then A=B=0x5A5A → 0x0000, eq=1, borrow=0.
- Positive overflow: A=0x7FFF, B=0xFFFF → ovf=1, lt=0. With SATURATE=1, out_diff=0x7FFF. With SATURATE=0, out_diff=0x8000.
- Negative overflow: A=0x8000, B=0x0001 → ovf=1, lt=1. With SATURATE=1, out_diff=0x8000. With SATURATE=0, out_diff=0x7FFF.
- Back-pressure: hold out_ready=0 for 3 cycles after out_valid. The outputs stay stable, in_ready=0, and a new in_valid is not consumed. Raise out_ready, and in_ready=1 on the next cycle.
- Reset mid-op: assert rst for one cycle after edge 2 of an operation → out_valid never asserts for it, and in_ready=1 afterwards. A following A=0x0100, B=0x0001 then yields 0x00FF.
